// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU field widths, capture record layout and select encodings
package alu_pkg;
  localparam int ALU_W = 5;
  localparam int SEL_W = 2;
  localparam int REC_W = SEL_W + 2 * ALU_W + ALU_W;
  localparam int OUT_LSB = 0;
  localparam int B_LSB = ALU_W;
  localparam int A_LSB = 2 * ALU_W;
  localparam int SEL_LSB = 3 * ALU_W;
  localparam logic [SEL_W-1:0] SEL_00 = 2'b00;
  localparam logic [SEL_W-1:0] SEL_01 = 2'b01;
  localparam logic [SEL_W-1:0] SEL_10 = 2'b10;
  localparam logic [SEL_W-1:0] SEL_11 = 2'b11;
endpackage

// File: rtl/alu_result_capture_fifo.sv
// sync_fifo: generic synchronous FIFO, extra pointer MSB separates full from empty
module sync_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             din_i,
  output logic                     push_ok_o,
  output logic [W-1:0]             dout_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic          pop_ok;
  assign level_o   = wr_ptr_q - rd_ptr_q;
  assign full_o    = level_o == PW'(DEPTH);
  assign valid_o   = level_o != '0;
  assign dout_o    = mem_q[rd_ptr_q[AW-1:0]];
  assign pop_ok    = pop_i && valid_o;
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign push_ok_o = push_i && (!full_o || pop_ok);
  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok_o};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_ok};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push_ok_o) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end
endmodule

// File: rtl/alu_result_capture.sv
// alu_result_capture: packs ALU transactions into a FIFO with per-select and drop statistics
module alu_result_capture import alu_pkg::*; #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cap_valid,
  input  logic [ALU_W-1:0]       cap_a,
  input  logic [ALU_W-1:0]       cap_b,
  input  logic [SEL_W-1:0]       cap_sel,
  input  logic [ALU_W-1:0]       cap_out,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [REC_W-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   overflow,
  output logic [CNT_W-1:0]       drop_cnt,
  output logic [CNT_W-1:0]       sel_cnt0,
  output logic [CNT_W-1:0]       sel_cnt1,
  output logic [CNT_W-1:0]       sel_cnt2,
  output logic [CNT_W-1:0]       sel_cnt3
);
  logic [REC_W-1:0] rec;
  logic             push_ok, drop;
  logic [CNT_W-1:0] sel_cnt_q [4];
  logic [CNT_W-1:0] sel_cnt_d [4];
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             overflow_q, overflow_d;
  assign rec[SEL_LSB +: SEL_W] = cap_sel;
  assign rec[A_LSB +: ALU_W]   = cap_a;
  assign rec[B_LSB +: ALU_W]   = cap_b;
  assign rec[OUT_LSB +: ALU_W] = cap_out;
  sync_fifo #(.W(REC_W), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_i    (cap_valid),
    .pop_i     (rd_ready),
    .din_i     (rec),
    .push_ok_o (push_ok),
    .dout_o    (rd_data),
    .valid_o   (rd_valid),
    .level_o   (level),
    .full_o    (full)
  );
  assign drop = cap_valid && !push_ok;
  always_comb begin
    for (int i = 0; i < 4; i++)
      sel_cnt_d[i] = (push_ok && cap_sel == SEL_W'(i) && sel_cnt_q[i] != '1) ? sel_cnt_q[i] + 1'b1 : sel_cnt_q[i];
    drop_cnt_d = (drop && drop_cnt_q != '1) ? drop_cnt_q + 1'b1 : drop_cnt_q;
    overflow_d = overflow_q || drop;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_cnt_q  <= '{default: '0};
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      sel_cnt_q  <= sel_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
    end
  end
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;
  assign sel_cnt0 = sel_cnt_q[SEL_00];
  assign sel_cnt1 = sel_cnt_q[SEL_01];
  assign sel_cnt2 = sel_cnt_q[SEL_10];
  assign sel_cnt3 = sel_cnt_q[SEL_11];
endmodule

// File: tb/tb_alu_result_capture.sv
// tb_alu_result_capture: directed table-driven and sequence checks of the capture FIFO
module tb_alu_result_capture;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cap_valid = 1'b0;
  logic [4:0]  cap_a = '0, cap_b = '0, cap_out = '0;
  logic [1:0]  cap_sel = '0;
  logic        rd_ready = 1'b0;
  logic        rd_valid, full, overflow;
  logic [16:0] rd_data;
  logic [3:0]  level;
  logic [7:0]  drop_cnt, sel_cnt0, sel_cnt1, sel_cnt2, sel_cnt3;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  alu_result_capture #(.DEPTH(8), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .cap_valid(cap_valid), .cap_a(cap_a), .cap_b(cap_b),
    .cap_sel(cap_sel), .cap_out(cap_out), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .level(level), .full(full), .overflow(overflow),
    .drop_cnt(drop_cnt), .sel_cnt0(sel_cnt0), .sel_cnt1(sel_cnt1),
    .sel_cnt2(sel_cnt2), .sel_cnt3(sel_cnt3)
  );
  typedef struct {
    logic [1:0]  sel;
    logic [4:0]  a, b, out;
    logic [16:0] exp_rec;
    logic [3:0]  exp_level;
  } vec_t;
  vec_t vecs [4];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [16:0] mk(input int i);
    logic [4:0] a, b, o;
    a = 5'(i);
    b = ~a;
    o = 5'(3 * i);
    return {2'(i), a, b, o};
  endfunction
  task automatic drive(input logic [16:0] r);
    cap_valid = 1'b1;
    {cap_sel, cap_a, cap_b, cap_out} = r;
  endtask
  task automatic do_reset;
    reset = 1'b1;
    cap_valid = 1'b0;
    rd_ready = 1'b0;
    tick();
    reset = 1'b0;
  endtask
  task automatic chk_cleared(input string tag);
    chk({tag, " rd_valid"}, 32'(rd_valid), 0);
    chk({tag, " level"}, 32'(level), 0);
    chk({tag, " full"}, 32'(full), 0);
    chk({tag, " overflow"}, 32'(overflow), 0);
    chk({tag, " drop_cnt"}, 32'(drop_cnt), 0);
    chk({tag, " sel_cnts"}, {sel_cnt0, sel_cnt1, sel_cnt2, sel_cnt3}, 0);
  endtask
  initial begin
    vecs[0] = '{2'b00, 5'b01100, 5'b10001, 5'b11101, 17'b00_01100_10001_11101, 4'd1};
    vecs[1] = '{2'b01, 5'b01100, 5'b10001, 5'b11011, 17'b01_01100_10001_11011, 4'd2};
    vecs[2] = '{2'b10, 5'b01100, 5'b10001, 5'b00000, 17'b10_01100_10001_00000, 4'd3};
    vecs[3] = '{2'b11, 5'b01100, 5'b10001, 5'b11101, 17'b11_01100_10001_11101, 4'd4};
    tick();
    do_reset();
    chk_cleared("reset");
    // basic ordering
    for (int i = 0; i < 4; i++) begin
      cap_valid = 1'b1;
      cap_sel = vecs[i].sel; cap_a = vecs[i].a; cap_b = vecs[i].b; cap_out = vecs[i].out;
      tick();
      chk("order level", 32'(level), 32'(vecs[i].exp_level));
      chk("order head", 32'(rd_data), 32'(vecs[0].exp_rec));
    end
    cap_valid = 1'b0;
    chk("order sel_cnts", {sel_cnt0, sel_cnt1, sel_cnt2, sel_cnt3}, 32'h01010101);
    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("order rd_valid", 32'(rd_valid), 1);
      chk("order rd_data", 32'(rd_data), 32'(vecs[i].exp_rec));
      tick();
      chk("order drain level", 32'(level), 32'(3 - i));
    end
    chk("order empty", 32'(rd_valid), 0);
    tick();
    chk("ready when empty", 32'(level), 0);
    // fill and overflow
    rd_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive(mk(i));
      tick();
      if (i == 7) begin
        chk("fill full", 32'(full), 1);
        chk("fill no overflow", 32'(overflow), 0);
      end
    end
    cap_valid = 1'b0;
    chk("overflow set", 32'(overflow), 1);
    chk("drop_cnt 1", 32'(drop_cnt), 1);
    chk("full level", 32'(level), 8);
    chk("stall head", 32'(rd_data), 32'(mk(0)));
    tick();
    chk("stall hold", 32'(rd_data), 32'(mk(0)));
    // push and pop while full
    drive({2'b01, 5'b11111, 5'b00001, 5'b00000});
    rd_ready = 1'b1;
    tick();
    cap_valid = 1'b0;
    chk("pp level", 32'(level), 8);
    chk("pp full", 32'(full), 1);
    chk("pp drop_cnt", 32'(drop_cnt), 1);
    chk("pp head", 32'(rd_data), 32'(mk(1)));
    for (int i = 1; i < 9; i++) begin
      chk("drain rd_data", 32'(rd_data), i < 8 ? 32'(mk(i)) : 32'(17'b01_11111_00001_00000));
      tick();
    end
    chk("drain empty", 32'(rd_valid), 0);
    chk("drain level", 32'(level), 0);
    // pointer wrap
    do_reset();
    rd_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      drive(mk(i + 5));
      tick();
      chk("wrap rd_valid", 32'(rd_valid), 1);
      chk("wrap rd_data", 32'(rd_data), 32'(mk(i + 5)));
      chk("wrap level", 32'(level), 1);
    end
    cap_valid = 1'b0;
    tick();
    chk("wrap final level", 32'(level), 0);
    chk("wrap overflow", 32'(overflow), 0);
    // saturation
    do_reset();
    rd_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      drive({2'b10, 5'(i), 5'd3, 5'd7});
      tick();
    end
    cap_valid = 1'b0;
    chk("sat sel_cnt2", 32'(sel_cnt2), 255);
    chk("sat others", {sel_cnt0, sel_cnt1, sel_cnt3}, 0);
    chk("sat drop", 32'(drop_cnt), 0);
    // mid-operation reset
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(mk(i));
      tick();
    end
    cap_valid = 1'b0;
    rd_ready = 1'b1;
    repeat (3) tick();
    rd_ready = 1'b0;
    chk("pre-reset level", 32'(level), 5);
    chk("pre-reset overflow", 32'(overflow), 1);
    reset = 1'b1;
    drive(mk(20));
    rd_ready = 1'b1;
    tick();
    reset = 1'b0;
    cap_valid = 1'b0;
    rd_ready = 1'b0;
    chk_cleared("mid reset");
    drive(mk(21));
    tick();
    cap_valid = 1'b0;
    chk("post-reset rd_valid", 32'(rd_valid), 1);
    chk("post-reset rd_data", 32'(rd_data), 32'(mk(21)));
    chk("post-reset level", 32'(level), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
